// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, framebuffer defaults and the timing-flag bundle
// that travels down the output delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_WIDTH_DEF  = 160;
    localparam int FB_HEIGHT_DEF = 120;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 15;
    localparam int PIX_W  = 3;

    // Sync levels are stored as they appear on the pins (active-low).
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic frame_start;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/vga_scanout_reader_if.sv
// Read port between the scanout reader and the two-bank pixel memory controller.
interface vga_scanout_reader_if;
    import vga_timing_pkg::*;

    // No valid/ready: a read is issued every cycle and q returns the pixel for
    // address/chip_select exactly MEM_LATENCY cycles later, unconditionally.
    logic [ADDR_W-1:0] address;
    logic              chip_select;
    logic [PIX_W-1:0]  q;

    modport master (output address, output chip_select, input q);
    modport slave  (input address, input chip_select, output q);

endinterface

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with raw (undelayed) timing flags,
// 4x-downscaled framebuffer coordinates and the bank-swap point strobe.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-3:0] fb_x,
    output logic [CNT_W-3:0] fb_y,
    output vga_flags_t       flags,
    output logic             swap_point
);

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACT + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACT + H_FRONT + H_SYNC_W - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT + H_FRONT + H_SYNC_W + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACT + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACT + V_FRONT + V_SYNC_W - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT + V_FRONT + V_SYNC_W + V_BACK - 1);
    localparam logic [CNT_W-1:0] V_SWAP   = CNT_W'(V_ACT - 1);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_comb begin
        flags             = FLAGS_IDLE;
        flags.active      = (h < H_ACT_C) && (v < V_ACT_C);
        flags.hs_n        = !((h >= HS_FIRST) && (h <= HS_LAST));
        flags.vs_n        = !((v >= VS_FIRST) && (v <= VS_LAST));
        flags.frame_start = (h == '0) && (v == '0);
    end

    // Last cycle of the last active line: the display bank has no reads left.
    assign swap_point = (h == H_LAST) && (v == V_SWAP);
    assign fb_x       = h[CNT_W-1:2];
    assign fb_y       = v[CNT_W-1:2];

endmodule

// File: rtl/vga_scanout_reader.sv
// VGA scanout: raster timing, 4x4-upscaled framebuffer reads from the display
// bank, double-buffer swap at the start of vertical blanking, RGB/sync outputs.
module vga_scanout_reader
    import vga_timing_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int FB_WIDTH    = FB_WIDTH_DEF,
    parameter int H_ACT       = H_ACTIVE,
    parameter int H_FRONT     = H_FP,
    parameter int H_SYNC_W    = H_SYNC,
    parameter int H_BACK      = H_BP,
    parameter int V_ACT       = V_ACTIVE,
    parameter int V_FRONT     = V_FP,
    parameter int V_SYNC_W    = V_SYNC,
    parameter int V_BACK      = V_BP
) (
    input  logic                 iClk,
    input  logic                 iResetn,
    vga_scanout_reader_if.master mem,
    input  logic                 iSwapReq,
    output logic                 oDrawBank,
    output logic                 oSwapAck,
    output logic [7:0]           oVGA_R,
    output logic [7:0]           oVGA_G,
    output logic [7:0]           oVGA_B,
    output logic                 oHS,
    output logic                 oVS,
    output logic                 oBlank_n,
    output logic                 oFrameStart
);

    // Counter -> address register -> memory -> colour register.
    localparam int DLY = 2 + MEM_LATENCY;

    logic [CNT_W-3:0]     fb_x;
    logic [CNT_W-3:0]     fb_y;
    vga_flags_t           flags;
    logic                 swap_point;
    logic                 swap_pending;
    logic [ADDR_W-1:0]    addr_next;
    vga_flags_t [DLY-1:0] flag_pipe;

    vga_timing_counter #(
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SYNC_W(H_SYNC_W),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SYNC_W(V_SYNC_W),
        .V_BACK  (V_BACK)
    ) u_counter (
        .clk       (iClk),
        .rst_n     (iResetn),
        .fb_x      (fb_x),
        .fb_y      (fb_y),
        .flags     (flags),
        .swap_point(swap_point)
    );

    generate
        if (FB_WIDTH == 160) begin : g_addr_shift
            // y*160 = y*128 + y*32, keeps a multiplier off the pixel path.
            assign addr_next = ADDR_W'({fb_y, 7'b0}) + ADDR_W'({fb_y, 5'b0}) + ADDR_W'(fb_x);
        end else begin : g_addr_mul
            assign addr_next = ADDR_W'(32'(fb_y) * FB_WIDTH + 32'(fb_x));
        end
    endgenerate

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            mem.address     <= '0;
            mem.chip_select <= 1'b0;
            swap_pending    <= 1'b0;
            oSwapAck        <= 1'b0;
        end else begin
            mem.address <= flags.active ? addr_next : '0;
            oSwapAck    <= 1'b0;
            if (swap_point && (swap_pending || iSwapReq)) begin
                mem.chip_select <= ~mem.chip_select;
                oSwapAck        <= 1'b1;
                swap_pending    <= 1'b0;
            end else if (iSwapReq) begin
                swap_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            flag_pipe <= {DLY{FLAGS_IDLE}};
        end else begin
            flag_pipe <= {flag_pipe[DLY-2:0], flags};
        end
    end

    // q belongs to the pixel whose flags sit one stage short of the output.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
        end else if (flag_pipe[DLY-2].active) begin
            oVGA_R <= {8{mem.q[2]}};
            oVGA_G <= {8{mem.q[1]}};
            oVGA_B <= {8{mem.q[0]}};
        end else begin
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
        end
    end

    assign oBlank_n    = flag_pipe[DLY-1].active;
    assign oHS         = flag_pipe[DLY-1].hs_n;
    assign oVS         = flag_pipe[DLY-1].vs_n;
    assign oFrameStart = flag_pipe[DLY-1].frame_start;
    assign oDrawBank   = ~mem.chip_select;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: a reduced-raster instance against a raster/bank
// reference model with random memory contents, plus a full 640x480 instance.
module tb_vga_scanout_reader;
    import vga_timing_pkg::*;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int SWAP_POS = (VA - 1) * HT + HT - 1;
    localparam int FBW = 160;
    localparam int VID_W = 7;
    localparam int BUS_W = 17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic swap_req = 1'b0;
    int   cyc;

    always #20 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- DUTs and memory models ----------------
    vga_scanout_reader_if mem_s ();
    vga_scanout_reader_if mem_f ();

    logic       draw_s, ack_s, hs_s, vs_s, blank_s, fs_s;
    logic [7:0] r_s, g_s, b_s;
    logic       draw_f, ack_f, hs_f, vs_f, blank_f, fs_f;
    logic [7:0] r_f, g_f, b_f;

    vga_scanout_reader #(
        .MEM_LATENCY(1), .FB_WIDTH(FBW),
        .H_ACT(HA), .H_FRONT(HF), .H_SYNC_W(HS), .H_BACK(HB),
        .V_ACT(VA), .V_FRONT(VF), .V_SYNC_W(VS), .V_BACK(VB)
    ) dut (
        .iClk(clk), .iResetn(rst_n), .mem(mem_s), .iSwapReq(swap_req),
        .oDrawBank(draw_s), .oSwapAck(ack_s),
        .oVGA_R(r_s), .oVGA_G(g_s), .oVGA_B(b_s),
        .oHS(hs_s), .oVS(vs_s), .oBlank_n(blank_s), .oFrameStart(fs_s)
    );

    vga_scanout_reader dut_full (
        .iClk(clk), .iResetn(rst_n), .mem(mem_f), .iSwapReq(1'b0),
        .oDrawBank(draw_f), .oSwapAck(ack_f),
        .oVGA_R(r_f), .oVGA_G(g_f), .oVGA_B(b_f),
        .oHS(hs_f), .oVS(vs_f), .oBlank_n(blank_f), .oFrameStart(fs_f)
    );

    logic [2:0] mem0 [32768];
    logic [2:0] mem1 [32768];

    always @(posedge clk) begin
        mem_s.q <= mem_s.chip_select ? mem1[mem_s.address] : mem0[mem_s.address];
        mem_f.q <= mem_f.address[2:0];
    end

    // ---------------- scoreboard ----------------
    logic [VID_W-1:0] vid_q[$];
    logic [BUS_W-1:0] bus_q[$];
    int   checks = 0;
    int   failures = 0;
    int   obs_acks = 0;
    bit   run_mon = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_bank = 0;
    bit m_pending = 0;
    int m_swaps = 0;
    bit post_reset = 0;

    task automatic step();
        int p, h, v, f, fp;
        logic req, act, ack, hs_n, vs_n, fs;
        logic [14:0] a;
        logic [2:0]  col;
        p = cyc; h = p % HT; v = (p / HT) % VT; f = p / FRAME; fp = p % FRAME;
        req = 1'b0;
        if (!post_reset) begin
            case (f)
                0: req = ($urandom_range(0, 1999) == 0);
                1: req = (fp == 1000);
                2: req = (fp == 400) || (fp == 800) || (fp == 1200);
                3: req = (fp == SWAP_POS) || (fp == SWAP_POS + 1);
                5: req = (fp == 2000);
                6: req = (fp == 800);
                default: req = 1'b0;
            endcase
        end
        swap_req = req;
        act  = (h < HA) && (v < VA);
        hs_n = !((h >= HA + HF) && (h < HA + HF + HS));
        vs_n = !((v >= VA + VF) && (v < VA + VF + VS));
        fs   = (h == 0) && (v == 0);
        a    = act ? 15'((v / 4) * FBW + h / 4) : 15'd0;
        col  = act ? (m_bank ? mem1[a] : mem0[a]) : 3'd0;
        vid_q.push_back({act, hs_n, vs_n, fs, col});
        ack = 1'b0;
        if ((h == HT - 1) && (v == VA - 1) && (m_pending || req)) begin
            m_bank = !m_bank;
            m_pending = 0;
            ack = 1'b1;
            m_swaps++;
        end else if (req) begin
            m_pending = 1;
        end
        bus_q.push_back({a, m_bank, ack});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [VID_W-1:0] ev;
        logic [BUS_W-1:0] eb;
        if (rst_n && run_mon) begin
            if (ack_s) obs_acks++;
            if (cyc == 0) begin
                check("addr_idle", 32'(mem_s.address), 32'd0);
                check("swap_ack_idle", 32'(ack_s), 32'd0);
            end else if (bus_q.size() == 0) begin
                check("bus_queue_empty", 32'd1, 32'd0);
            end else begin
                eb = bus_q.pop_front();
                check("address", 32'(mem_s.address), 32'(eb[16:2]));
                check("chip_select", 32'(mem_s.chip_select), 32'(eb[1]));
                check("draw_bank", 32'(draw_s), 32'(!eb[1]));
                check("swap_ack", 32'(ack_s), 32'(eb[0]));
            end
            if (cyc < 3) begin
                check("blank_flush", 32'(blank_s), 32'd0);
                check("sync_flush", 32'({hs_s, vs_s}), 32'd3);
                check("rgb_flush", 32'({r_s, g_s, b_s}), 32'd0);
            end else if (vid_q.size() == 0) begin
                check("vid_queue_empty", 32'd1, 32'd0);
            end else begin
                ev = vid_q.pop_front();
                check("blank_n", 32'(blank_s), 32'(ev[6]));
                check("hsync", 32'(hs_s), 32'(ev[5]));
                check("vsync", 32'(vs_s), 32'(ev[4]));
                check("frame_start", 32'(fs_s), 32'(ev[3]));
                check("rgb", 32'({r_s, g_s, b_s}),
                      32'({{8{ev[6] & ev[2]}}, {8{ev[6] & ev[1]}}, {8{ev[6] & ev[0]}}}));
            end
        end
    end

    // ---------------- full-size raster spot checks ----------------
    initial begin
        wait (rst_n === 1'b1);
        repeat (3300) begin
            @(negedge clk);
            if (cyc >= 1 && cyc <= 8) check("full_addr_line0", 32'(mem_f.address), 32'((cyc - 1) / 4));
            if (cyc == 3201) check("full_addr_line4", 32'(mem_f.address), 32'd160);
            if (cyc == 3205) check("full_addr_line4_x1", 32'(mem_f.address), 32'd161);
            if (cyc == 658)  check("full_hs_before", 32'(hs_f), 32'd1);
            if (cyc == 659)  check("full_hs_fall", 32'(hs_f), 32'd0);
            if (cyc == 754)  check("full_hs_last_low", 32'(hs_f), 32'd0);
            if (cyc == 755)  check("full_hs_rise", 32'(hs_f), 32'd1);
            if (cyc == 1459) check("full_hs_period", 32'(hs_f), 32'd0);
            if (cyc == 2)    check("full_blank_pre", 32'(blank_f), 32'd0);
            if (cyc == 3)    check("full_blank_first", 32'(blank_f), 32'd1);
            if (cyc == 3)    check("full_frame_start", 32'(fs_f), 32'd1);
            if (cyc == 642)  check("full_blank_last", 32'(blank_f), 32'd1);
            if (cyc == 643)  check("full_blank_end", 32'(blank_f), 32'd0);
            if (cyc == 803)  check("full_blank_line1", 32'(blank_f), 32'd1);
            if (cyc == 7)    check("full_rgb_px4", 32'({r_f, g_f, b_f}), 32'h0000ff);
            if (cyc == 27)   check("full_rgb_px24", 32'({r_f, g_f, b_f}), 32'hffff00);
            if (cyc == 642)  check("full_rgb_px639", 32'({r_f, g_f, b_f}), 32'hffffff);
        end
    end

    // ---------------- driver ----------------
    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem0[i] = 3'($urandom);
            mem1[i] = 3'($urandom);
        end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_mon = 1;
        repeat (6 * FRAME + 1600) begin
            step();
            @(posedge clk);
            #1;
        end

        // Mid-frame reset with a swap pending.
        check("pending_before_reset", 32'(m_pending), 32'd1);
        rst_n = 1'b0;
        swap_req = 1'b0;
        #1;
        check("rst_address", 32'(mem_s.address), 32'd0);
        check("rst_chip_select", 32'(mem_s.chip_select), 32'd0);
        check("rst_draw_bank", 32'(draw_s), 32'd1);
        check("rst_swap_ack", 32'(ack_s), 32'd0);
        check("rst_rgb", 32'({r_s, g_s, b_s}), 32'd0);
        check("rst_syncs", 32'({hs_s, vs_s}), 32'd3);
        check("rst_blank_fs", 32'({blank_s, fs_s}), 32'd0);
        vid_q.delete();
        bus_q.delete();
        m_bank = 0;
        m_pending = 0;
        post_reset = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (FRAME + 200) begin
            step();
            @(posedge clk);
            #1;
        end

        check("swap_count", 32'(obs_acks), 32'(m_swaps));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scanout_reader.md
# vga_scanout_reader

Read-side counterpart of the two-bank pixel memory controller: generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock, issues read addresses into the display bank, and turns returned 3-bit pixels into VGA RGB/sync outputs. The 160x120 framebuffer is upscaled 4x4. Double buffering is managed here. The display bank is exposed for scanout. Its complement is offered to the drawing path. Swaps take effect only at the start of vertical blanking.

## Interface
- MEM_LATENCY, 1: cycles from oAddress/oChipSelect change to matching iQ.
- FB_WIDTH, 160: framebuffer pixels per row (row stride).
- iClk  in  1  25 MHz pixel clock; all state on rising edge.
- iResetn  in  1  asynchronous, active-low reset.
- iQ  in  3  pixel {R,G,B} returned by memory controller.
- iSwapReq  in  1  single-cycle request to exchange display/draw banks.
- oAddress  out  15  framebuffer read address, registered.
- oChipSelect  out  1  bank being displayed (0 = bank 0), registered.
- oDrawBank  out  1  ~oChipSelect; bank the drawing side may write.
- oSwapAck  out  1  one-cycle pulse when a swap is applied.
- oVGA_R, oVGA_G, oVGA_B  out  8 each  {8{colour bit}}; 0 when blanked.
- oHS, oVS  out  1 each  active-low syncs.
- oBlank_n  out  1  high during active video.
- oFrameStart  out  1  one-cycle pulse aligned with pixel (0,0) on outputs.

## Operation
- Counters: h 0..799 (640 active, 16 FP, 96 sync, 48 BP), v 0..524 (480 active, 10 FP, 2 sync, 33 BP). v advances when h wraps 799->0. v wraps 524->0.
- Active when h<640 and v<480. HS low for h in 656..751. VS low for v in 490..491.
- Address: (v>>2)*FB_WIDTH + (h>>2), computed as (v>>2)<<7 + (v>>2)<<5 + (h>>2). Max 19199, no overflow in 15 bits. Outside active region, oAddress = 0.
- Swap pending flag: set by iSwapReq and cleared on swap.
  - Swap point: counter cycle h=799, v=479.
  - If the pending flag is set, or iSwapReq is high in that same cycle, oChipSelect toggles on the next edge, oSwapAck pulses high for that one cycle, and the pending flag clears.
  - Multiple requests before the swap point coalesce into one swap.
  - A request arriving in the cycle after the swap point waits a full frame.
- Colour: oVGA_* = {8{iQ[bit]}} when the delayed active flag is set, else 0. R=iQ[2], G=iQ[1], B=iQ[0].
- Reset (async assert, sync release), all registers:
  - Counters, oAddress, oChipSelect (bank 0), pending flag, oSwapAck, oBlank_n, oFrameStart, RGB: 0.
  - oHS, oVS: 1.
  - oDrawBank: 1.
  - Delay pipelines flushed to the inactive state.
- Reset mid-frame: output restarts at (0,0) on bank 0. Any pending swap is lost.

## Timing
- Counter state is stage 0. oAddress/oChipSelect register at stage 1. iQ is valid at stage 1+MEM_LATENCY. RGB register at stage 2+MEM_LATENCY.
- Active, HS, VS and frame-start flags are delayed by the same 2+MEM_LATENCY cycles. All VGA outputs stay mutually aligned (default 3 cycles after counters).
- oChipSelect toggles at least 160 cycles after the last active-pixel address. No in-flight read crosses banks.
- oSwapAck is coincident with the first cycle oChipSelect shows the new bank.

## Structure
- Shared package vga_timing_pkg holds H/V active, front-porch, sync and back-porch constants, totals, and FB_WIDTH/FB_HEIGHT defaults.
- Sub-module vga_timing_counter holds the h/v counters and produces raw active/HS/VS/frame-start.
- The top level holds address generation, the bank/swap logic, delay lines and colour expansion.

## Test plan
- Reset then run one frame -> HS period 800 cycles with a 96-cycle low pulse, VS period 420000 cycles with a 1600-cycle low pulse, 640x480 oBlank_n-high region.
- Memory model (MEM_LATENCY=1) returning addr[2:0] -> oAddress sequence 0,0,0,0,1,… on line 0. Line 4 starts at 160. Last active address is 19199. RGB at output pixel (h,v) matches the colour of address (v>>2)*160+(h>>2), 3 cycles after the counter.
- Pulse iSwapReq mid-frame -> oChipSelect 0->1 and oSwapAck high exactly one cycle after counter (799,479). Next frame reads bank 1. oDrawBank = 0.
- Three iSwapReq pulses in one frame -> exactly one toggle. iSwapReq at the swap-point cycle -> honoured that frame. iSwapReq one cycle later -> applied one frame later.
- Assert iResetn low at v=200 with a swap pending -> outputs return to reset values immediately. After release, the counter restarts at (0,0), oChipSelect=0, and no oSwapAck occurs at the next swap point.
